// File: rtl/xrv_pkg.sv
// xrv_pkg: shared decode types for the xrv decode stage.
//   - RV32 base opcode constants (OP_LUI..OP_REG) and the M-extension funct7
//   - xrv_imm_fmt_e: immediate format selected per opcode class
//   - xrv_dec_t: decoded instruction record handed from ID to EX
package xrv_pkg;

    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_REG      = 7'b0110011;

    localparam logic [6:0] MEXT_FUNCT7 = 7'b0000001;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } xrv_imm_fmt_e;

    typedef struct packed {
        logic        is_lui;
        logic        is_auipc;
        logic        is_jal;
        logic        is_jalr;
        logic        is_branch;
        logic        is_load;
        logic        is_store;
        logic        is_imm;
        logic        is_reg;
        logic        illegal;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm_signed;
        logic [31:0] imm_unsigned;
        logic [31:0] pc;
        logic        compressed;
        logic        is_mext;
        logic        pred_taken;
    } xrv_dec_t;

endpackage

// File: rtl/xrv_id_dec.sv
// xrv_id_dec: purely combinational single-instruction decoder.
//   i_inst/i_pc/i_compressed -> o_dec (xrv_dec_t)
//   o_redir : instruction is a static redirect (JAL, or backward branch if EN_BPRED)
//   o_target: i_pc + sign-extended immediate, wraps modulo 2^32
module xrv_id_dec
    import xrv_pkg::*;
#(
    parameter bit EN_BPRED = 1'b1,
    parameter bit EN_MEXT  = 1'b1
) (
    input  logic [31:0] i_inst,
    input  logic [31:0] i_pc,
    input  logic        i_compressed,
    output xrv_dec_t    o_dec,
    output logic        o_redir,
    output logic [31:0] o_target
);

    logic [6:0]   w_op;
    logic [8:0]   w_cls;
    xrv_imm_fmt_e w_fmt;
    logic [20:0]  w_j;
    logic [12:0]  w_b;
    logic [11:0]  w_i;
    logic [11:0]  w_s;
    logic [31:0]  w_imm_s;
    logic [31:0]  w_imm_u;

    assign w_op = i_inst[6:0];
    // Full 7-bit compare: a non-11 low pair can never match a class.
    assign w_cls = {w_op == OP_LUI,    w_op == OP_AUIPC, w_op == OP_JAL,
                    w_op == OP_JALR,   w_op == OP_BRANCH, w_op == OP_LOAD,
                    w_op == OP_STORE,  w_op == OP_IMM,    w_op == OP_REG};

    assign w_j = {i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
    assign w_b = {i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
    assign w_i = i_inst[31:20];
    assign w_s = {i_inst[31:25], i_inst[11:7]};

    always_comb begin
        w_fmt = IMM_NONE;
        unique case (1'b1)
            w_cls[8], w_cls[7]           : w_fmt = IMM_U;
            w_cls[6]                     : w_fmt = IMM_J;
            w_cls[5], w_cls[3], w_cls[1] : w_fmt = IMM_I;
            w_cls[4]                     : w_fmt = IMM_B;
            w_cls[2]                     : w_fmt = IMM_S;
            default                      : w_fmt = IMM_NONE;
        endcase
    end

    always_comb begin
        w_imm_s = '0;
        w_imm_u = '0;
        case (w_fmt)
            IMM_U: begin
                w_imm_s = {i_inst[31:12], 12'b0};
                w_imm_u = {i_inst[31:12], 12'b0};
            end
            IMM_J: begin
                w_imm_s = {{11{w_j[20]}}, w_j};
                w_imm_u = {11'b0, w_j};
            end
            IMM_I: begin
                w_imm_s = {{20{w_i[11]}}, w_i};
                w_imm_u = {20'b0, w_i};
            end
            IMM_B: begin
                w_imm_s = {{19{w_b[12]}}, w_b};
                w_imm_u = {19'b0, w_b};
            end
            IMM_S: begin
                w_imm_s = {{20{w_s[11]}}, w_s};
                w_imm_u = {20'b0, w_s};
            end
            default: ;
        endcase
    end

    // Backward branch = negative offset = inst[31] set.
    assign o_redir  = w_cls[6] | (EN_BPRED & w_cls[4] & i_inst[31]);
    assign o_target = i_pc + w_imm_s;

    always_comb begin
        o_dec              = '0;
        {o_dec.is_lui, o_dec.is_auipc, o_dec.is_jal, o_dec.is_jalr, o_dec.is_branch,
         o_dec.is_load, o_dec.is_store, o_dec.is_imm, o_dec.is_reg} = w_cls;
        o_dec.illegal      = (i_inst[1:0] != 2'b11) | ~|w_cls;
        o_dec.rs1          = i_inst[19:15];
        o_dec.rs2          = i_inst[24:20];
        o_dec.rd           = i_inst[11:7];
        o_dec.funct3       = i_inst[14:12];
        o_dec.funct7       = i_inst[31:25];
        o_dec.imm_signed   = w_imm_s;
        o_dec.imm_unsigned = w_imm_u;
        o_dec.pc           = i_pc;
        o_dec.compressed   = i_compressed;
        o_dec.is_mext      = EN_MEXT & w_cls[0] & (i_inst[31:25] == MEXT_FUNCT7);
        // Only enqueued records are ever seen, and those are exactly the
        // ones for which a redirect is issued, so the static flag suffices.
        o_dec.pred_taken   = o_redir;
    end

endmodule

// File: rtl/xrv_id_pipe.sv
// xrv_id_pipe: elastic decode stage between xrv_if and xrv_ex.
//   clk/rstb      : clock, async active-low reset
//   flush         : EX-side flush, clears queue and cancels pending redirect
//   in_*          : fetch handshake + instruction/pc/compressed flag
//   out_*         : DEPTH-entry FIFO head toward EX, decoded record out_dec
//   id_jmp/_addr  : one-cycle early redirect pulse and its held target
// Redirects put the stage in WAIT, where wrong-path fetches are accepted
// and dropped until the target pc shows up.
module xrv_id_pipe
    import xrv_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter bit EN_BPRED = 1'b1,
    parameter bit EN_MEXT  = 1'b1
) (
    input  logic        clk,
    input  logic        rstb,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_inst,
    input  logic [31:0] in_pc,
    input  logic        in_compressed,
    output logic        out_valid,
    input  logic        out_ready,
    output xrv_dec_t    out_dec,
    output logic        id_jmp,
    output logic [31:0] id_jmp_addr
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    xrv_dec_t      r_mem [DEPTH];
    logic [PW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_cnt;
    logic [0:0]    r_state;
    logic          r_jmp;
    logic [31:0]   r_jmp_addr;

    xrv_dec_t      w_dec;
    logic          w_redir;
    logic [31:0]   w_target;
    logic          w_accept, w_push, w_pop, w_jmp;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    xrv_id_dec #(
        .EN_BPRED (EN_BPRED),
        .EN_MEXT  (EN_MEXT)
    ) u_dec (
        .i_inst       (in_inst),
        .i_pc         (in_pc),
        .i_compressed (in_compressed),
        .o_dec        (w_dec),
        .o_redir      (w_redir),
        .o_target     (w_target)
    );

    assign in_ready  = (r_cnt < CW'(DEPTH));
    assign out_valid = (r_cnt != '0);
    assign out_dec   = out_valid ? r_mem[r_rptr] : '0;
    assign id_jmp      = r_jmp;
    assign id_jmp_addr = r_jmp_addr;

    assign w_accept = in_valid & in_ready & ~flush;
    // In WAIT the only instruction kept is the redirect target itself.
    assign w_push   = w_accept & ((r_state == ST_RUN) | (in_pc == r_jmp_addr));
    assign w_pop    = out_valid & out_ready;
    assign w_jmp    = w_push & w_redir;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= w_dec;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_cnt      <= '0;
            r_state    <= ST_RUN;
            r_jmp      <= 1'b0;
            r_jmp_addr <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_cnt   <= '0;
            r_state <= ST_RUN;
            r_jmp   <= 1'b0;
        end else begin
            r_jmp <= w_jmp;
            if (w_jmp)       r_jmp_addr <= w_target;
            if (w_jmp)       r_state    <= ST_WAIT;
            else if (w_push) r_state    <= ST_RUN;
            if (w_push) r_wptr <= f_inc(r_wptr);
            if (w_pop)  r_rptr <= f_inc(r_rptr);
            if (w_push & ~w_pop)      r_cnt <= r_cnt + 1'b1;
            else if (~w_push & w_pop) r_cnt <= r_cnt - 1'b1;
        end
    end

endmodule
